// File: rtl/pkmn_game_pkg.sv
// Shared types and constants for the main-game screen: facing directions,
// sequencer states, USB HID key codes and the default tile size.
package pkmn_game_pkg;

   typedef enum logic [1:0] {
      DOWN  = 2'd0,
      UP    = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TURN  = 2'd1,
      ST_QUERY = 2'd2,
      ST_STEP  = 2'd3
   } step_state_t;

   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_B     = 8'h05;
   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam logic [7:0] KEY_ESC   = 8'h29;

   localparam int TILE_PX_DEFAULT = 16;

   // Returns {valid, dir}; any code that is not WASD decodes as "no key".
   function automatic logic [2:0] key_decode(input logic [7:0] code);
      logic [2:0] res;
      case (code)
         KEY_S:   res = {1'b1, DOWN};
         KEY_W:   res = {1'b1, UP};
         KEY_A:   res = {1'b1, LEFT};
         KEY_D:   res = {1'b1, RIGHT};
         default: res = 3'b000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: brings the raw VGA vertical sync into the Clk domain
// and emits a one-cycle pulse on each synchronised rising edge.
module frame_tick_gen (
   input  logic Clk,
   input  logic Reset,
   input  logic i_vga_vs,
   output logic o_tick
);

   logic [2:0] r_vs_sync;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_vs_sync <= 3'b000;
      end else begin
         r_vs_sync <= {r_vs_sync[1:0], i_vga_vs};
      end
   end

   // Bits [1:0] form the synchroniser pair, bit 2 is the edge-detect history.
   assign o_tick = r_vs_sync[1] & ~r_vs_sync[2];

endmodule

// File: rtl/char_step_ctrl.sv
// Player tile-step sequencer: WASD -> turn / collision query / one-tile step,
// advanced once per video frame. Optional running via `PKMN_RUN_EN (adds run_btn).
module char_step_ctrl
   import pkmn_game_pkg::*;
#(
   parameter int TILE_PX     = TILE_PX_DEFAULT,
   parameter int MAP_W       = 32,
   parameter int MAP_H       = 32,
   parameter int WALK_SPD    = 1,
   parameter int TURN_FRAMES = 4,
   parameter int START_X     = 5,
   parameter int START_Y     = 5
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       VGA_VS,
   input  logic                       enable,
   input  logic [7:0]                 keycode,
`ifdef PKMN_RUN_EN
   input  logic                       run_btn,
`endif
   output logic                       blk_req,
   output logic [$clog2(MAP_W)-1:0]   blk_x,
   output logic [$clog2(MAP_H)-1:0]   blk_y,
   input  logic                       blk_ack,
   input  logic                       blk_solid,
   output logic [$clog2(MAP_W)-1:0]   pos_x,
   output logic [$clog2(MAP_H)-1:0]   pos_y,
   output logic [$clog2(TILE_PX)-1:0] offset,
   output logic [1:0]                 direction,
   output logic                       moving,
   output logic [1:0]                 walk_frame
);

   localparam int XW = $clog2(MAP_W);
   localparam int YW = $clog2(MAP_H);
   localparam int OW = $clog2(TILE_PX);
   localparam int SW = OW + 2;
   localparam int CW = (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;

   step_state_t   r_state, w_state_next;
   logic [XW-1:0] r_pos_x, w_pos_x_next, r_tgt_x, w_tgt_x_next, w_cand_x;
   logic [YW-1:0] r_pos_y, w_pos_y_next, r_tgt_y, w_tgt_y_next, w_cand_y;
   logic [OW-1:0] r_offset, w_offset_next;
   dir_t          r_dir, w_dir_next, w_key_dir;
   logic          r_blk_req, w_blk_req_next;
   logic          r_parity, w_parity_next;
   logic          r_run, w_run_next;
   logic [CW-1:0] r_turn_cnt, w_turn_cnt_next;
   logic          w_tick, w_run_in, w_key_vld, w_off_map;
   logic [2:0]    w_key;
   logic [SW-1:0] w_spd, w_off_sum;

   frame_tick_gen u_tick (
      .Clk      (Clk),
      .Reset    (Reset),
      .i_vga_vs (VGA_VS),
      .o_tick   (w_tick)
   );

`ifdef PKMN_RUN_EN
   assign w_run_in = run_btn;
`else
   assign w_run_in = 1'b0;
`endif

   assign w_key     = key_decode(keycode);
   assign w_key_vld = w_key[2];
   assign w_key_dir = dir_t'(w_key[1:0]);

   // Neighbouring tile in the pressed direction and whether it leaves the map.
   always_comb begin
      w_cand_x  = r_pos_x;
      w_cand_y  = r_pos_y;
      w_off_map = 1'b0;
      case (w_key_dir)
         DOWN: begin
            w_off_map = (r_pos_y == YW'(MAP_H - 1));
            w_cand_y  = r_pos_y + 1'b1;
         end
         UP: begin
            w_off_map = (r_pos_y == '0);
            w_cand_y  = r_pos_y - 1'b1;
         end
         LEFT: begin
            w_off_map = (r_pos_x == '0);
            w_cand_x  = r_pos_x - 1'b1;
         end
         default: begin
            w_off_map = (r_pos_x == XW'(MAP_W - 1));
            w_cand_x  = r_pos_x + 1'b1;
         end
      endcase
   end

   assign w_spd     = r_run ? SW'(2 * WALK_SPD) : SW'(WALK_SPD);
   assign w_off_sum = {2'b00, r_offset} + w_spd;

   always_comb begin
      w_state_next    = r_state;
      w_pos_x_next    = r_pos_x;
      w_pos_y_next    = r_pos_y;
      w_tgt_x_next    = r_tgt_x;
      w_tgt_y_next    = r_tgt_y;
      w_offset_next   = r_offset;
      w_dir_next      = r_dir;
      w_blk_req_next  = r_blk_req;
      w_parity_next   = r_parity;
      w_run_next      = r_run;
      w_turn_cnt_next = r_turn_cnt;
      if (!enable) begin
         w_state_next   = ST_IDLE;
         w_offset_next  = '0;
         w_blk_req_next = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_tick && w_key_vld) begin
                  if (w_key_dir != r_dir) begin
                     w_dir_next      = w_key_dir;
                     w_turn_cnt_next = '0;
                     w_state_next    = ST_TURN;
                  end else if (!w_off_map) begin
                     w_tgt_x_next   = w_cand_x;
                     w_tgt_y_next   = w_cand_y;
                     w_blk_req_next = 1'b1;
                     w_state_next   = ST_QUERY;
                  end
               end
            end
            ST_TURN: begin
               if (w_tick) begin
                  if (r_turn_cnt == CW'(TURN_FRAMES - 1)) begin
                     w_state_next = ST_IDLE;
                  end else begin
                     w_turn_cnt_next = r_turn_cnt + 1'b1;
                  end
               end
            end
            ST_QUERY: begin
               if (blk_ack) begin
                  w_blk_req_next = 1'b0;
                  if (blk_solid) begin
                     w_state_next = ST_IDLE;
                  end else begin
                     w_state_next  = ST_STEP;
                     w_offset_next = '0;
                     w_run_next    = w_run_in;
                  end
               end
            end
            default: begin
               if (w_tick) begin
                  if (w_off_sum >= SW'(TILE_PX)) begin
                     w_pos_x_next  = r_tgt_x;
                     w_pos_y_next  = r_tgt_y;
                     w_offset_next = '0;
                     w_parity_next = ~r_parity;
                     w_state_next  = ST_IDLE;
                  end else begin
                     w_offset_next = w_off_sum[OW-1:0];
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state    <= ST_IDLE;
         r_pos_x    <= XW'(START_X);
         r_pos_y    <= YW'(START_Y);
         r_tgt_x    <= '0;
         r_tgt_y    <= '0;
         r_offset   <= '0;
         r_dir      <= DOWN;
         r_blk_req  <= 1'b0;
         r_parity   <= 1'b0;
         r_run      <= 1'b0;
         r_turn_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_pos_x    <= w_pos_x_next;
         r_pos_y    <= w_pos_y_next;
         r_tgt_x    <= w_tgt_x_next;
         r_tgt_y    <= w_tgt_y_next;
         r_offset   <= w_offset_next;
         r_dir      <= w_dir_next;
         r_blk_req  <= w_blk_req_next;
         r_parity   <= w_parity_next;
         r_run      <= w_run_next;
         r_turn_cnt <= w_turn_cnt_next;
      end
   end

   assign blk_req    = r_blk_req;
   assign blk_x      = r_tgt_x;
   assign blk_y      = r_tgt_y;
   assign pos_x      = r_pos_x;
   assign pos_y      = r_pos_y;
   assign offset     = r_offset;
   assign direction  = r_dir;
   assign moving     = (r_state == ST_STEP);
   // Stride frame shows for the first half of the tile, standing pose for the rest.
   assign walk_frame = !moving                     ? 2'd0 :
                       (r_offset < OW'(TILE_PX/2)) ? (r_parity ? 2'd2 : 2'd1) : 2'd0;

endmodule

// File: tb/tb_char_step_ctrl.sv
// Self-checking bench for char_step_ctrl: table of key vectors, hand-written
// multi-frame sequences and a randomized run against a frame-level model.
module tb_char_step_ctrl;

   localparam int TILE  = 16;
   localparam int TURNF = 4;
   localparam int MW    = 32;
   localparam int MH    = 32;

   logic       Clk       = 1'b0;
   logic       Reset     = 1'b1;
   logic       VGA_VS    = 1'b0;
   logic       enable    = 1'b1;
   logic [7:0] keycode   = 8'h00;
   logic       blk_ack   = 1'b0;
   logic       blk_solid = 1'b0;
`ifdef PKMN_RUN_EN
   logic       run_btn   = 1'b0;
`endif
   logic       blk_req, moving;
   logic [4:0] blk_x, blk_y, pos_x, pos_y;
   logic [3:0] offset;
   logic [1:0] direction, walk_frame;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [7:0] key;
      int         exp_dir;
      int         exp_req;
      int         exp_bx;
      int         exp_by;
   } vec_t;

   vec_t       vecs[7];
   logic [7:0] keys[6];

   char_step_ctrl dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .VGA_VS     (VGA_VS),
      .enable     (enable),
      .keycode    (keycode),
`ifdef PKMN_RUN_EN
      .run_btn    (run_btn),
`endif
      .blk_req    (blk_req),
      .blk_x      (blk_x),
      .blk_y      (blk_y),
      .blk_ack    (blk_ack),
      .blk_solid  (blk_solid),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .offset     (offset),
      .direction  (direction),
      .moving     (moving),
      .walk_frame (walk_frame)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
   endtask

   task automatic do_reset();
      @(posedge Clk); #1;
      Reset = 1'b1; VGA_VS = 1'b0; blk_ack = 1'b0; blk_solid = 1'b0;
      keycode = 8'h00; enable = 1'b1;
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
   endtask

   // One video frame: VS pulse, then enough cycles for the tick to land and settle.
   task automatic tick_frame();
      @(posedge Clk); #1 VGA_VS = 1'b1;
      repeat (3) @(posedge Clk);
      #1 VGA_VS = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
   endtask

   task automatic respond(input logic solid, input int dly);
      repeat (dly) @(posedge Clk);
      #1;
      chk("req_held_before_ack", int'(blk_req), 1);
      blk_ack = 1'b1; blk_solid = solid;
      @(posedge Clk); #1;
      blk_ack = 1'b0; blk_solid = 1'b0;
      chk("req_drop_after_ack", int'(blk_req), 0);
   endtask

   function automatic int key_dir(input logic [7:0] k);
      case (k)
         8'h16:   return 0;
         8'h1A:   return 1;
         8'h04:   return 2;
         8'h07:   return 3;
         default: return -1;
      endcase
   endfunction

   initial begin
      int m_x, m_y, m_dir, m_turn, m_px, m_par, m_tx, m_ty, kd, nx, ny;
      bit m_step, q, solid;
      logic [7:0] key;

      vecs[0] = '{8'h16, 0, 1, 5, 6};
      vecs[1] = '{8'h1A, 1, 0, 0, 0};
      vecs[2] = '{8'h04, 2, 0, 0, 0};
      vecs[3] = '{8'h07, 3, 0, 0, 0};
      vecs[4] = '{8'h05, 0, 0, 0, 0};
      vecs[5] = '{8'h00, 0, 0, 0, 0};
      vecs[6] = '{8'h28, 0, 0, 0, 0};
      keys = '{8'h16, 8'h1A, 8'h04, 8'h07, 8'h00, 8'h05};

      // Reset state
      do_reset();
      chk("rst_pos_x", int'(pos_x), 5);
      chk("rst_pos_y", int'(pos_y), 5);
      chk("rst_offset", int'(offset), 0);
      chk("rst_dir", int'(direction), 0);
      chk("rst_moving", int'(moving), 0);
      chk("rst_walk_frame", int'(walk_frame), 0);
      chk("rst_blk_req", int'(blk_req), 0);

      // Table: one tick from reset with each key, then a reset pulse
      for (int i = 0; i < 7; i++) begin
         do_reset();
         keycode = vecs[i].key;
         tick_frame();
         chk($sformatf("vec%0d_dir", i), int'(direction), vecs[i].exp_dir);
         chk($sformatf("vec%0d_req", i), int'(blk_req), vecs[i].exp_req);
         chk($sformatf("vec%0d_moving", i), int'(moving), 0);
         chk($sformatf("vec%0d_pos", i), int'(pos_x) * 100 + int'(pos_y), 505);
         if (vecs[i].exp_req != 0) begin
            chk($sformatf("vec%0d_blk_x", i), int'(blk_x), vecs[i].exp_bx);
            chk($sformatf("vec%0d_blk_y", i), int'(blk_y), vecs[i].exp_by);
         end
         @(posedge Clk); #1 Reset = 1'b1;
         @(posedge Clk); #1 Reset = 1'b0;
         chk($sformatf("vec%0d_rst_req", i), int'(blk_req), 0);
         chk($sformatf("vec%0d_rst_pos", i), int'(pos_x) * 100 + int'(pos_y), 505);
         chk($sformatf("vec%0d_rst_dir", i), int'(direction), 0);
      end

      // Walk down three tiles: gapless steps, stride frames 1,2,1
      do_reset();
      keycode = 8'h16;
      for (int s = 0; s < 3; s++) begin
         tick_frame();
         chk("down_req", int'(blk_req), 1);
         chk("down_blk_x", int'(blk_x), 5);
         chk("down_blk_y", int'(blk_y), 6 + s);
         respond(1'b0, 3);
         chk("down_moving", int'(moving), 1);
         chk("down_offset0", int'(offset), 0);
         chk("down_stride", int'(walk_frame), (s % 2 == 0) ? 1 : 2);
         for (int t = 1; t <= TILE; t++) begin
            tick_frame();
            if (t < TILE) begin
               chk("down_offset", int'(offset), t);
               chk("down_frame", int'(walk_frame), (t < TILE / 2) ? ((s % 2 == 0) ? 1 : 2) : 0);
               chk("down_mid_pos_y", int'(pos_y), 5 + s);
            end else begin
               chk("down_end_pos_y", int'(pos_y), 6 + s);
               chk("down_end_offset", int'(offset), 0);
               chk("down_end_moving", int'(moving), 0);
               chk("down_end_frame", int'(walk_frame), 0);
            end
         end
      end

      // Turn right, solid tile, retry, enable drop mid-step and during a query
      do_reset();
      keycode = 8'h07;
      tick_frame();
      chk("turn_dir", int'(direction), 3);
      chk("turn_req", int'(blk_req), 0);
      for (int t = 0; t < TURNF; t++) begin
         tick_frame();
         chk("turn_hold_req", int'(blk_req), 0);
         chk("turn_hold_moving", int'(moving), 0);
      end
      tick_frame();
      chk("right_req", int'(blk_req), 1);
      chk("right_blk_x", int'(blk_x), 6);
      chk("right_blk_y", int'(blk_y), 5);
      respond(1'b1, 2);
      chk("solid_moving", int'(moving), 0);
      chk("solid_pos_x", int'(pos_x), 5);
      tick_frame();
      chk("requery_req", int'(blk_req), 1);
      chk("requery_blk_x", int'(blk_x), 6);
      respond(1'b0, 1);
      chk("right_moving", int'(moving), 1);
      repeat (8) tick_frame();
      chk("pre_drop_offset", int'(offset), 8);
      @(posedge Clk); #1 enable = 1'b0;
      @(posedge Clk); #1;
      chk("drop_offset", int'(offset), 0);
      chk("drop_moving", int'(moving), 0);
      chk("drop_req", int'(blk_req), 0);
      chk("drop_pos_x", int'(pos_x), 5);
      chk("drop_dir", int'(direction), 3);
      chk("drop_frame", int'(walk_frame), 0);
      enable = 1'b1;
      tick_frame();
      chk("q_drop_req_before", int'(blk_req), 1);
      @(posedge Clk); #1 enable = 1'b0;
      @(posedge Clk); #1 enable = 1'b1;
      chk("q_drop_req", int'(blk_req), 0);
      blk_ack = 1'b1;
      @(posedge Clk); #1 blk_ack = 1'b0;
      chk("q_drop_ack_ignored", int'(moving), 0);

      // Walk left to the map edge, then push against it
      do_reset();
      keycode = 8'h04;
      repeat (1 + TURNF) tick_frame();
      chk("left_dir", int'(direction), 2);
      for (int s = 0; s < 5; s++) begin
         tick_frame();
         chk("left_req", int'(blk_req), 1);
         chk("left_blk_x", int'(blk_x), 4 - s);
         respond(1'b0, 1);
         repeat (TILE) tick_frame();
         chk("left_pos_x", int'(pos_x), 4 - s);
      end
      for (int t = 0; t < 10; t++) begin
         tick_frame();
         chk("edge_req", int'(blk_req), 0);
         chk("edge_pos_x", int'(pos_x), 0);
         chk("edge_moving", int'(moving), 0);
      end

`ifdef PKMN_RUN_EN
      do_reset();
      run_btn = 1'b1;
      keycode = 8'h16;
      tick_frame();
      respond(1'b0, 2);
      for (int t = 1; t <= 8; t++) begin
         tick_frame();
         if (t < 8) chk("run_offset", int'(offset), 2 * t);
         else chk("run_pos_y", int'(pos_y), 6);
      end
      run_btn = 1'b0;
`endif

      // Randomized frames against a frame-level model
      do_reset();
      m_x = 5; m_y = 5; m_dir = 0; m_turn = 0; m_px = 0; m_par = 0; m_step = 0;
      m_tx = 0; m_ty = 0;
      key = 8'h00;
      for (int t = 0; t < 150; t++) begin
         if ($urandom_range(3) == 0) key = keys[$urandom_range(5)];
         keycode = key;
         kd = key_dir(key);
         q = 1'b0;
         if (m_step) begin
            m_px = m_px + 1;
            if (m_px >= TILE) begin
               m_x = m_tx; m_y = m_ty; m_px = 0; m_step = 0; m_par = 1 - m_par;
            end
         end else if (m_turn > 0) begin
            m_turn = m_turn - 1;
         end else if (kd >= 0) begin
            if (kd != m_dir) begin
               m_dir = kd; m_turn = TURNF;
            end else begin
               nx = m_x + ((kd == 3) ? 1 : (kd == 2) ? -1 : 0);
               ny = m_y + ((kd == 0) ? 1 : (kd == 1) ? -1 : 0);
               if (nx >= 0 && nx < MW && ny >= 0 && ny < MH) begin
                  q = 1'b1; m_tx = nx; m_ty = ny;
               end
            end
         end
         tick_frame();
         if (q) begin
            chk("rnd_req", int'(blk_req), 1);
            chk("rnd_blk_x", int'(blk_x), m_tx);
            chk("rnd_blk_y", int'(blk_y), m_ty);
            solid = 1'($urandom_range(1));
            respond(solid, $urandom_range(4));
            if (!solid) begin
               m_step = 1; m_px = 0;
            end
         end else begin
            chk("rnd_no_req", int'(blk_req), 0);
         end
         chk("rnd_pos_x", int'(pos_x), m_x);
         chk("rnd_pos_y", int'(pos_y), m_y);
         chk("rnd_offset", int'(offset), m_px);
         chk("rnd_dir", int'(direction), m_dir);
         chk("rnd_moving", int'(moving), int'(m_step));
         chk("rnd_frame", int'(walk_frame),
             m_step ? ((m_px < TILE / 2) ? ((m_par != 0) ? 2 : 1) : 0) : 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
